strm_gen: RTL and testbench

STRM_GEN -- requirements
Module: strm_gen

---
 rtl/strm_gen.sv | 237 +++++++++++++++++++++++
 tb/tb_strm_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strm_gen.sv
// strm_gen: soft-register controlled stream generator.
// A start write launches a run of N words. Each word carries LANES 32-bit
// lanes derived from either an incrementing counter or a Galois LFSR. The
// words are split into packets of pkt_len words and tdest rotates over
// dest_cnt destinations. Cycle, stall and checksum statistics are kept and
// can be read back over the soft-register port.
//
// Stream handshake: a word transfers on every rising edge where tvalid and
// tready are both high. Once tvalid is raised it stays high, with tdata,
// tdest and tlast held constant, until that transfer happens. tready may
// change freely and never depends on tvalid inside this block.
module strm_gen #(
  parameter int DATA_W = 512,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              softreg_req_valid,
  input  logic              softreg_req_is_write,
  input  logic [31:0]       softreg_req_addr,
  input  logic [63:0]       softreg_req_data,
  output logic              softreg_resp_valid,
  output logic [63:0]       softreg_resp_data,
  output logic              axis_m_tvalid,
  output logic [DATA_W-1:0] axis_m_tdata,
  output logic [DEST_W-1:0] axis_m_tdest,
  output logic              axis_m_tlast,
  input  logic              axis_m_tready,
  output logic              dbg_state
);

  localparam int          LANES = DATA_W / 32;
  // Bit 0 of the tap constant marks the feedback stage itself; after the
  // right shift it has no destination, so only bits 31:1 are XORed in.
  localparam logic [31:0] TAPS  = 32'h8020_0003;

  localparam logic [31:0] A_SEED  = 32'h00;
  localparam logic [31:0] A_PLEN  = 32'h08;
  localparam logic [31:0] A_DCNT  = 32'h10;
  localparam logic [31:0] A_MODE  = 32'h18;
  localparam logic [31:0] A_START = 32'h20;
  localparam logic [31:0] A_SENT  = 32'h28;
  localparam logic [31:0] A_CYC   = 32'h30;
  localparam logic [31:0] A_RNV   = 32'h38;
  localparam logic [31:0] A_VNR   = 32'h40;
  localparam logic [31:0] A_CSUM  = 32'h48;
  localparam logic [31:0] A_STAT  = 32'h50;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // configuration (stored already normalised: pkt_len >= 1, 1 <= dest_cnt <= 32)
  logic [31:0] seed;
  logic [15:0] pkt_len;
  logic [5:0]  dest_cnt;
  logic        mode;

  // run state
  logic [33:0] words;
  logic [33:0] sent;
  logic [31:0] pat;
  logic [15:0] pkt_pos;
  logic [5:0]  dest_idx;
  logic        tvalid_q;

  // statistics
  logic [47:0] cyc;
  logic [47:0] rnv;
  logic [47:0] vnr;
  logic [31:0] checksum;

  logic        wr;
  logic        rd;
  logic        cfg_wr_ok;
  logic        start_wr;
  logic        run_req;
  logic        hs;
  logic        final_hs;
  logic        last_word;
  logic [5:0]  dest_cnt_wr;
  logic [15:0] pkt_len_wr;
  logic        unused_bits;

  assign unused_bits = ^softreg_req_data[63:34];

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    lfsr_next = (v >> 1) ^ (v[0] ? {TAPS[31:1], 1'b0} : 32'h0);
  endfunction

  // Request decode: config and start writes only land while idle.
  always_comb begin
    wr        = softreg_req_valid && softreg_req_is_write;
    rd        = softreg_req_valid && !softreg_req_is_write;
    cfg_wr_ok = wr && (state_q == S_IDLE);
    start_wr  = cfg_wr_ok && (softreg_req_addr == A_START);
    run_req   = start_wr && (softreg_req_data[33:0] != 34'd0);
    hs        = tvalid_q && axis_m_tready;
    final_hs  = hs && (words == 34'd1);
    last_word = (pkt_pos == pkt_len - 16'd1) || (words == 34'd1);
  end

  // Normalise incoming pkt_len / dest_cnt values before storing them.
  always_comb begin
    pkt_len_wr = softreg_req_data[15:0];
    if (softreg_req_data[15:0] == 16'd0) pkt_len_wr = 16'd1;
    dest_cnt_wr = softreg_req_data[5:0];
    if (softreg_req_data[5:0] == 6'd0)
      dest_cnt_wr = 6'd1;
    else if (softreg_req_data[5:0] > 6'd32)
      dest_cnt_wr = 6'd32;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: launch on a nonzero start, finish on the last transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (run_req)  state_d = S_RUN;
      S_RUN:   if (final_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // tvalid is registered and simply tracks the RUN state one edge ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tvalid_q <= 1'b0;
    else        tvalid_q <= (state_d == S_RUN);
  end

  // Stream outputs: lanes are pat + lane index; all fields depend only on
  // registers that change on a transfer, so they hold during a stall.
  always_comb begin
    axis_m_tdata = '0;
    for (int i = 0; i < LANES; i++) begin
      axis_m_tdata[i*32 +: 32] = pat + 32'(i);
    end
    axis_m_tvalid = tvalid_q;
    axis_m_tlast  = tvalid_q && last_word;
    axis_m_tdest  = DEST_W'(dest_idx);
    dbg_state     = (state_q == S_RUN);
  end

  // Configuration registers, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed     <= 32'd0;
      pkt_len  <= 16'd1;
      dest_cnt <= 6'd1;
      mode     <= 1'b0;
    end else if (cfg_wr_ok) begin
      case (softreg_req_addr)
        A_SEED:  seed     <= softreg_req_data[31:0];
        A_PLEN:  pkt_len  <= pkt_len_wr;
        A_DCNT:  dest_cnt <= dest_cnt_wr;
        A_MODE:  mode     <= softreg_req_data[0];
        default: ;
      endcase
    end
  end

  // Run datapath and statistics: a start write reloads everything,
  // otherwise the pattern, indices and counters advance per transfer/cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words    <= 34'd0;
      sent     <= 34'd0;
      pat      <= 32'd0;
      pkt_pos  <= 16'd0;
      dest_idx <= 6'd0;
      cyc      <= 48'd0;
      rnv      <= 48'd0;
      vnr      <= 48'd0;
      checksum <= 32'd0;
    end else if (start_wr) begin
      words    <= softreg_req_data[33:0];
      sent     <= 34'd0;
      pat      <= (mode && seed == 32'd0) ? 32'd1 : seed;
      pkt_pos  <= 16'd0;
      dest_idx <= 6'd0;
      cyc      <= 48'd0;
      rnv      <= 48'd0;
      vnr      <= 48'd0;
      checksum <= 32'd0;
    end else begin
      if (state_q == S_RUN) begin
        cyc <= cyc + 48'd1;
        if (axis_m_tready && !tvalid_q) rnv <= rnv + 48'd1;
      end
      if (tvalid_q && !axis_m_tready) vnr <= vnr + 48'd1;
      if (hs) begin
        words    <= words - 34'd1;
        sent     <= sent + 34'd1;
        checksum <= checksum + pat;
        pat      <= mode ? lfsr_next(pat) : pat + 32'(LANES);
        if (last_word) begin
          pkt_pos  <= 16'd0;
          dest_idx <= (dest_idx == dest_cnt - 6'd1) ? 6'd0 : dest_idx + 6'd1;
        end else begin
          pkt_pos  <= pkt_pos + 16'd1;
        end
      end
    end
  end

  // Read port: one-cycle latency; unmapped addresses keep the last data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      softreg_resp_valid <= 1'b0;
      softreg_resp_data  <= 64'd0;
    end else begin
      softreg_resp_valid <= rd;
      if (rd) begin
        case (softreg_req_addr)
          A_SEED:  softreg_resp_data <= {31'd0, seed, mode};
          A_START: softreg_resp_data <= {30'd0, words};
          A_SENT:  softreg_resp_data <= {30'd0, sent};
          A_CYC:   softreg_resp_data <= {16'd0, cyc};
          A_RNV:   softreg_resp_data <= {16'd0, rnv};
          A_VNR:   softreg_resp_data <= {16'd0, vnr};
          A_CSUM:  softreg_resp_data <= {32'd0, checksum};
          A_STAT:  softreg_resp_data <= {41'd0, (state_q == S_RUN), pkt_pos, dest_idx};
          default: softreg_resp_data <= softreg_resp_data;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_strm_gen.sv
// tb_strm_gen: directed bench for strm_gen with hand-computed expectations.
module tb_strm_gen;

  localparam int DATA_W = 512;
  localparam int DEST_W = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              req_valid;
  logic              req_is_write;
  logic [31:0]       req_addr;
  logic [63:0]       req_data;
  logic              resp_valid;
  logic [63:0]       resp_data;
  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic [DEST_W-1:0] tdest;
  logic              tlast;
  logic              tready;
  logic              dbg_state;

  strm_gen #(.DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .softreg_req_valid    (req_valid),
    .softreg_req_is_write (req_is_write),
    .softreg_req_addr     (req_addr),
    .softreg_req_data     (req_data),
    .softreg_resp_valid   (resp_valid),
    .softreg_resp_data    (resp_data),
    .axis_m_tvalid        (tvalid),
    .axis_m_tdata         (tdata),
    .axis_m_tdest         (tdest),
    .axis_m_tlast         (tlast),
    .axis_m_tready        (tready),
    .dbg_state            (dbg_state)
  );

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // scoreboard of observed transfers
  logic [DATA_W-1:0] mon_data[$];
  logic              mon_last[$];
  logic [DEST_W-1:0] mon_dest[$];
  int                hold_err = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [DEST_W-1:0] prev_dest;
  logic              prev_last;
  logic [63:0]       last_vec;
  logic [63:0]       dest_vec;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: record transfers, and flag any stalled
  // word whose fields change or whose tvalid drops before it is accepted.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!tvalid || tdata !== prev_data || tdest !== prev_dest || tlast !== prev_last))
        hold_err <= hold_err + 1;
      if (tvalid && tready) begin
        mon_data.push_back(tdata);
        mon_last.push_back(tlast);
        mon_dest.push_back(tdest);
      end
      prev_stall <= tvalid && !tready;
      prev_data  <= tdata;
      prev_dest  <= tdest;
      prev_last  <= tlast;
    end
  end

  // driver tasks
  task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
    @(posedge clk); #1;
    req_valid = 1'b1; req_is_write = 1'b1; req_addr = a; req_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_is_write = 1'b0;
  endtask

  task automatic sr_read(input logic [31:0] a, input logic [63:0] exp, input string tag);
    @(posedge clk); #1;
    req_valid = 1'b1; req_is_write = 1'b0; req_addr = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, "_vld"}, {63'd0, resp_valid}, 64'd1);
    chk(tag, resp_data, exp);
    @(posedge clk); #1;
    chk({tag, "_vld_drop"}, {63'd0, resp_valid}, 64'd0);
  endtask

  task automatic clear_mon();
    mon_data.delete();
    mon_last.delete();
    mon_dest.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tvalid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("run_end", {63'd0, tvalid}, 64'd0);
  endtask

  task automatic collect();
    last_vec = '0;
    dest_vec = '0;
    for (int i = 0; i < mon_last.size() && i < 64; i++) last_vec[i] = mon_last[i];
    for (int i = 0; i < mon_dest.size() && i < 12; i++) dest_vec[i*5 +: 5] = mon_dest[i];
  endtask

  initial begin
    int n;
    int seen;
    req_valid = 1'b0; req_is_write = 1'b0; req_addr = '0; req_data = '0;
    tready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
    chk("rst_tlast", {63'd0, tlast}, 64'd0);
    chk("rst_tdest", {59'd0, tdest}, 64'd0);
    chk("rst_resp_vld", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_state", {63'd0, dbg_state}, 64'd0);
    rst_n = 1'b1;
    sr_read(32'h00, 64'd0, "rst_cfg");
    sr_read(32'h28, 64'd0, "rst_sent");

    // counter mode, 8 words, packets of 4, 3 destinations
    tready = 1'b1;
    sr_write(32'h00, 64'h100);
    sr_write(32'h08, 64'd4);
    sr_write(32'h10, 64'd3);
    sr_write(32'h18, 64'd0);
    clear_mon();
    sr_write(32'h20, 64'd8);
    wait_idle();
    collect();
    chk("t1_beats", 64'(mon_data.size()), 64'd8);
    chk("t1_w1_l0", {32'd0, mon_data[1][31:0]}, 64'h110);
    chk("t1_w0_l15", {32'd0, mon_data[0][511:480]}, 64'h10F);
    chk("t1_w7_l0", {32'd0, mon_data[7][31:0]}, 64'h170);
    chk("t1_last", last_vec, 64'b1000_1000);
    chk("t1_dest", dest_vec, {24'd0, 5'd1, 5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0});
    repeat (2) @(posedge clk);
    #1;
    chk("t1_tvalid_after", {63'd0, tvalid}, 64'd0);
    sr_read(32'h28, 64'd8, "t1_sent");
    sr_read(32'h60, 64'd8, "t1_unmapped");
    sr_read(32'h48, 64'h9C0, "t1_csum");
    sr_read(32'h30, 64'd8, "t1_cyc");
    sr_read(32'h50, 64'd2, "t1_status");
    sr_read(32'h00, 64'h200, "t1_cfg");

    // start with count 0 only clears statistics
    sr_write(32'h20, 64'd0);
    chk("clr_state", {63'd0, dbg_state}, 64'd0);
    chk("clr_tvalid", {63'd0, tvalid}, 64'd0);
    sr_read(32'h28, 64'd0, "clr_sent");
    sr_read(32'h48, 64'd0, "clr_csum");

    // back-pressure: tready toggles every cycle, 5 words
    tready = 1'b0;
    clear_mon();
    sr_write(32'h20, 64'd5);
    n = 0;
    while (tvalid && n < 100) begin
      tready = ~tready;
      @(posedge clk); #1;
      n++;
    end
    chk("t2_end", {63'd0, tvalid}, 64'd0);
    collect();
    chk("t2_beats", 64'(mon_data.size()), 64'd5);
    chk("t2_w4_l0", {32'd0, mon_data[4][31:0]}, 64'h140);
    chk("t2_last", last_vec, 64'b11000);
    chk("t2_hold", 64'(hold_err), 64'd0);
    sr_read(32'h40, 64'd4, "t2_vnr");
    sr_read(32'h38, 64'd0, "t2_rnv");
    sr_read(32'h30, 64'd9, "t2_cyc");
    sr_read(32'h48, 64'h5A0, "t2_csum");

    // LFSR mode with seed 0
    tready = 1'b1;
    sr_write(32'h18, 64'd1);
    sr_write(32'h00, 64'd0);
    clear_mon();
    sr_write(32'h20, 64'd3);
    wait_idle();
    collect();
    chk("t3_beats", 64'(mon_data.size()), 64'd3);
    chk("t3_w0_l0", {32'd0, mon_data[0][31:0]}, 64'h1);
    chk("t3_w1_l0", {32'd0, mon_data[1][31:0]}, 64'h8020_0002);
    chk("t3_w2_l0", {32'd0, mon_data[2][31:0]}, 64'h4010_0001);
    chk("t3_w1_l15", {32'd0, mon_data[1][511:480]}, 64'h8020_0011);
    chk("t3_last", last_vec, 64'b100);
    sr_read(32'h00, 64'd1, "t3_cfg");
    sr_read(32'h48, 64'hC030_0004, "t3_csum");

    // short final packet: pkt_len 3, dest_cnt 2, 7 words
    sr_write(32'h18, 64'd0);
    sr_write(32'h08, 64'd3);
    sr_write(32'h10, 64'd2);
    clear_mon();
    sr_write(32'h20, 64'd7);
    wait_idle();
    collect();
    chk("t4_beats", 64'(mon_data.size()), 64'd7);
    chk("t4_last", last_vec, 64'b110_0100);
    chk("t4_dest", dest_vec, {29'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0});
    chk("t4_w6_l0", {32'd0, mon_data[6][31:0]}, 64'h60);

    // pkt_len 0 acts as 1, dest_cnt 40 clamps to 32, 33 single-word packets
    sr_write(32'h08, 64'd0);
    sr_write(32'h10, 64'd40);
    clear_mon();
    sr_write(32'h20, 64'd33);
    wait_idle();
    collect();
    chk("t4b_beats", 64'(mon_data.size()), 64'd33);
    chk("t4b_last", last_vec, 64'h1_FFFF_FFFF);
    chk("t4b_dest5", {59'd0, mon_dest[5]}, 64'd5);
    sr_read(32'h50, 64'd1, "t4b_status");

    // dest_cnt 0 acts as 1
    sr_write(32'h10, 64'd0);
    clear_mon();
    sr_write(32'h20, 64'd3);
    wait_idle();
    collect();
    chk("t4c_dest", dest_vec, 64'd0);
    sr_read(32'h50, 64'd0, "t4c_status");

    // writes during a run are ignored
    sr_write(32'h08, 64'd4);
    sr_write(32'h10, 64'd3);
    sr_write(32'h00, 64'h100);
    clear_mon();
    sr_write(32'h20, 64'd6);
    sr_write(32'h08, 64'd2);
    sr_write(32'h20, 64'd100);
    wait_idle();
    collect();
    chk("t5_beats", 64'(mon_data.size()), 64'd6);
    chk("t5_last", last_vec, 64'b10_1000);
    sr_read(32'h20, 64'd0, "t5_words");
    sr_read(32'h28, 64'd6, "t5_sent");

    // reset in the middle of a 10-word run
    clear_mon();
    sr_write(32'h20, 64'd10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_tvalid_drop", {63'd0, tvalid}, 64'd0);
    chk("t6_tlast_drop", {63'd0, tlast}, 64'd0);
    chk("t6_state", {63'd0, dbg_state}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (tvalid) seen++;
    end
    chk("t6_quiet", 64'(seen), 64'd0);
    chk("t6_beats", 64'(mon_data.size()), 64'd2);
    sr_read(32'h20, 64'd0, "t6_words");
    sr_read(32'h28, 64'd0, "t6_sent");
    sr_read(32'h00, 64'd0, "t6_cfg");
    clear_mon();
    sr_write(32'h20, 64'd2);
    wait_idle();
    collect();
    chk("t6_restart_beats", 64'(mon_data.size()), 64'd2);
    chk("t6_restart_w1", {32'd0, mon_data[1][31:0]}, 64'h10);
    chk("t6_restart_last", last_vec, 64'b11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
